// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC memory/peripheral bus.
package soc_bus_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single Wishbone classic port between data (priority) and fetch,
// with a stall output for the pipeline and a watchdog that force-terminates hung cycles.
module mem_port_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_sel,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                bus_cyc,
  output logic                bus_stb,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [ADDR_W-1:0]   bus_adr,
  output logic [DATA_W-1:0]   bus_dat_o,
  input  logic [DATA_W-1:0]   bus_dat_i,
  input  logic                bus_ack,
  output logic                stall_pipl,
  output logic                bus_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             kill_seen;
  logic             dm_elig;
  logic             if_elig;
  logic             fetch_killed;
  logic             done;

  // A request whose ack is being pulsed this cycle is still high but already served.
  assign dm_elig      = dm_req & ~dm_ack;
  assign if_elig      = if_req & ~if_ack;
  assign fetch_killed = kill_seen | if_kill;
  assign done         = bus_cyc & (bus_ack | (cnt == CNT_MAX));

  assign bus_stb    = bus_cyc;
  assign stall_pipl = (dm_req & ~dm_ack) | (if_req & ~if_ack & ~if_kill);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      kill_seen   <= 1'b0;
      bus_cyc     <= 1'b0;
      bus_we      <= 1'b0;
      bus_sel     <= '0;
      bus_adr     <= '0;
      bus_dat_o   <= '0;
      if_ack      <= 1'b0;
      if_rdata    <= '0;
      dm_ack      <= 1'b0;
      dm_rdata    <= '0;
      bus_timeout <= 1'b0;
    end else begin
      if_ack      <= 1'b0;
      dm_ack      <= 1'b0;
      bus_timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          kill_seen <= 1'b0;
          if (dm_elig) begin
            state     <= DATA;
            bus_cyc   <= 1'b1;
            bus_we    <= dm_we;
            bus_sel   <= dm_sel;
            bus_adr   <= dm_addr;
            bus_dat_o <= dm_wdata;
          end else if (if_elig) begin
            state   <= FETCH;
            bus_cyc <= 1'b1;
            bus_we  <= 1'b0;
            bus_sel <= '1;
            bus_adr <= if_addr;
          end
        end

        DATA: begin
          if (done) begin
            bus_cyc     <= 1'b0;
            bus_timeout <= ~bus_ack;
            dm_ack      <= 1'b1;
            dm_rdata    <= bus_ack ? bus_dat_i : '0;
            cnt         <= '0;
            kill_seen   <= 1'b0;
            // Fetch is queued straight behind the data access; strobe rises next cycle.
            if (if_elig) begin
              state   <= FETCH;
              bus_we  <= 1'b0;
              bus_sel <= '1;
              bus_adr <= if_addr;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        FETCH: begin
          kill_seen <= fetch_killed;
          if (!bus_cyc) begin
            // Launch cycle after a data ack: counter holds at zero until strobe is up.
            bus_cyc <= 1'b1;
          end else if (done) begin
            state       <= IDLE;
            bus_cyc     <= 1'b0;
            bus_timeout <= ~bus_ack;
            if (!fetch_killed) begin
              if_ack   <= 1'b1;
              if_rdata <= bus_ack ? bus_dat_i : DATA_W'(NOP_INSTR);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state   <= IDLE;
          bus_cyc <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction rounds scored cycle-by-cycle against a timeline model,
// plus directed scenarios with literal expectations and a mid-transaction reset.
module tb_mem_port_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [3:0]  dm_sel;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        bus_cyc, bus_stb, bus_we, bus_ack, stall_pipl, bus_timeout;
  logic [3:0]  bus_sel;
  logic [31:0] bus_adr, bus_dat_o, bus_dat_i;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel), .bus_adr(bus_adr),
    .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i), .bus_ack(bus_ack),
    .stall_pipl(stall_pipl), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  int cyc_no = 0;
  int round0 = 0;
  int last_dm_ack_cyc = 0, last_if_ack_cyc = 0, n_tmo = 0, n_if_ack = 0, n_dm_ack = 0;

  // Expected outputs for the current cycle
  logic        e_cyc, e_we, e_dm_ack, e_if_ack, e_tmo, e_stall, e_dat_chk;
  logic [3:0]  e_sel;
  logic [31:0] e_adr, e_dat;
  logic [31:0] m_dm_rdata = '0, m_if_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc_no, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc_no++;
    if (dm_ack) begin last_dm_ack_cyc = cyc_no; n_dm_ack++; end
    if (if_ack) begin last_if_ack_cyc = cyc_no; n_if_ack++; end
    if (bus_timeout) n_tmo++;
    if (chk_en) begin
      chk("bus_cyc", 32'(bus_cyc), 32'(e_cyc));
      chk("bus_stb", 32'(bus_stb), 32'(e_cyc));
      chk("dm_ack", 32'(dm_ack), 32'(e_dm_ack));
      chk("if_ack", 32'(if_ack), 32'(e_if_ack));
      chk("bus_timeout", 32'(bus_timeout), 32'(e_tmo));
      chk("stall_pipl", 32'(stall_pipl), 32'(e_stall));
      chk("dm_rdata", dm_rdata, m_dm_rdata);
      chk("if_rdata", if_rdata, m_if_rdata);
      if (e_cyc) begin
        chk("bus_adr", bus_adr, e_adr);
        chk("bus_we", 32'(bus_we), 32'(e_we));
        chk("bus_sel", 32'(bus_sel), 32'(e_sel));
        if (e_dat_chk) chk("bus_dat_o", bus_dat_o, e_dat);
      end
    end
  end

  // One round: optional data access then optional fetch, both requested at cycle 0 in IDLE.
  // Waits above TO mean the slave never acks. Timeline is derived by plain arithmetic.
  task automatic run_round(input bit hd, input bit dwe, input logic [31:0] daddr,
                           input logic [3:0] dsel, input logic [31:0] dwd, input int dwait,
                           input bit hf, input logic [31:0] faddr, input int fwait,
                           input bit fkill, input int koff, input int gap,
                           input bit fixdat, input logic [31:0] fdatv);
    bit dto, fto, in_d, in_f;
    int dlen, dack, fstart, flen, fack, kc, last;
    logic [31:0] din, ddat, fdat;
    dto = dwait > TO;  dlen = (dto ? TO : dwait) + 1;  dack = 1 + dlen;
    fto = fwait > TO;  flen = (fto ? TO : fwait) + 1;
    fstart = hd ? dack + 1 : 1;
    fack = fstart + flen;
    kc = (hf && fkill) ? fstart + (koff % flen) : 1000;
    last = hf ? fack : dack;
    ddat = '0; fdat = '0;
    for (int c = 0; c <= last + gap; c++) begin
      @(posedge clk); #1;
      if (c == 0) round0 = cyc_no + 1;
      din = fixdat ? fdatv : $urandom;
      bus_dat_i = din;
      dm_we = dwe; dm_addr = daddr; dm_sel = dsel; dm_wdata = dwd; if_addr = faddr;
      dm_req  = hd && c <= dack;
      if_req  = hf && c <= fack && c <= kc;
      if_kill = (c == kc);
      in_d = hd && c >= 1 && c < dack;
      in_f = hf && c >= fstart && c < fack;
      if (in_d)                      bus_ack = (c == 1 + dwait);
      else if (in_f)                 bus_ack = (c == fstart + fwait);
      else if (hd && hf && c == dack) bus_ack = 1'b0;
      else                           bus_ack = 1'($urandom_range(0, 1));
      if (in_d && bus_ack) ddat = din;
      if (in_f && bus_ack) fdat = din;
      e_cyc = in_d | in_f;
      e_adr = in_d ? daddr : faddr;
      e_we  = in_d ? dwe : 1'b0;
      e_sel = in_d ? dsel : 4'hF;
      e_dat = dwd;
      e_dat_chk = in_d;
      e_dm_ack = hd && c == dack;
      e_if_ack = hf && c == fack && !fkill;
      e_tmo = (hd && c == dack && dto) || (hf && c == fack && fto);
      if (e_dm_ack) m_dm_rdata = dto ? 32'h0 : ddat;
      if (e_if_ack) m_if_rdata = fto ? NOP : fdat;
      e_stall = (dm_req & ~e_dm_ack) | (if_req & ~e_if_ack & ~if_kill);
      chk_en = 1;
    end
    @(posedge clk); #1;
    chk_en = 0;
    dm_req = 0; if_req = 0; if_kill = 0; bus_ack = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc_no);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_ack, t_tmo, pat;
    reset = 1; if_req = 0; if_kill = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_sel = 0;
    dm_addr = 0; dm_wdata = 0; bus_dat_i = 0; bus_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_cyc", 32'(bus_cyc), 32'h0);
    chk("rst_bus_stb", 32'(bus_stb), 32'h0);
    chk("rst_bus_adr", bus_adr, 32'h0);
    chk("rst_bus_sel", 32'(bus_sel), 32'h0);
    chk("rst_bus_dat", bus_dat_o, 32'h0);
    chk("rst_acks", {30'h0, dm_ack, if_ack}, 32'h0);
    chk("rst_rdata", dm_rdata | if_rdata, 32'h0);
    chk("rst_timeout", 32'(bus_timeout), 32'h0);
    @(negedge clk); reset = 0;

    // Zero-wait load
    run_round(1, 0, 32'h1000_0004, 4'hF, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    chk("zw_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("zw_latency", 32'(last_dm_ack_cyc - round0), 32'd2);

    // Contention: store then fetch, one wait state each
    run_round(1, 1, 32'h2000_0000, 4'hF, 32'hA5A5_A5A5, 1, 1, 32'h0000_0040, 1, 0, 0, 1, 1, 32'h1234_5678);
    chk("cont_gap", 32'(last_if_ack_cyc - last_dm_ack_cyc), 32'd3);
    chk("cont_ifdat", if_rdata, 32'h1234_5678);

    // Flush mid-fetch, slave acks 3 cycles after the kill
    t_ack = n_if_ack;
    run_round(0, 0, 0, 0, 0, 0, 1, 32'h0000_0080, 3, 1, 0, 1, 1, 32'h7777_7777);
    chk("flush_noack", 32'(n_if_ack - t_ack), 32'd0);
    chk("flush_rdata", if_rdata, 32'h1234_5678);

    // Fetch timeout
    t_tmo = n_tmo;
    run_round(0, 0, 0, 0, 0, 0, 1, 32'h0000_00C0, 9, 0, 0, 1, 0, 0);
    chk("tmo_pulses", 32'(n_tmo - t_tmo), 32'd1);
    chk("tmo_nop", if_rdata, 32'h0000_0013);
    chk("tmo_latency", 32'(last_if_ack_cyc - round0), 32'd6);

    // Back-to-back loads
    t_ack = n_dm_ack;
    run_round(1, 0, 32'h3000_0000, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_round(1, 0, 32'h3000_0004, 4'hC, 0, 2, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("b2b_acks", 32'(n_dm_ack - t_ack), 32'd2);

    for (int r = 0; r < 40; r++) begin
      pat = $urandom_range(1, 3);
      run_round(pat[0], 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
                $urandom_range(0, 5), pat[1], $urandom, $urandom_range(0, 5),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 2), 0, 0);
    end

    // Reset during a data wait state
    @(posedge clk); #1;
    dm_req = 1; dm_we = 0; dm_addr = 32'h2000_0008; dm_sel = 4'hF; bus_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_pre", 32'(bus_cyc), 32'h1);
    t_ack = n_dm_ack;
    reset = 1; #1;
    chk("rst_mid_cyc", 32'(bus_cyc), 32'h0);
    chk("rst_mid_ack", 32'(dm_ack), 32'h0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("regrant_cyc", 32'(bus_cyc), 32'h1);
    chk("regrant_adr", bus_adr, 32'h2000_0008);
    chk("rst_no_ack", 32'(n_dm_ack - t_ack), 32'd0);
    bus_ack = 1; bus_dat_i = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_ack = 0;
    chk("regrant_ack", 32'(dm_ack), 32'h1);
    chk("regrant_rdata", dm_rdata, 32'hCAFE_F00D);
    chk("regrant_drop", 32'(bus_cyc), 32'h0);
    dm_req = 0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
